// File: rtl/dataflow_ctrl_sequencer_if.sv
// dataflow_ctrl_sequencer_if: top-level handshake, per-process control
// and watchdog signals of one dataflow region.
interface dataflow_ctrl_sequencer_if #(
    parameter int N_PROC = 3
);
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic [N_PROC-1:0] proc_start;
    logic [N_PROC-1:0] proc_ready;
    logic [N_PROC-1:0] proc_done;
    logic [N_PROC-1:0] proc_idle;
    logic              stall;
    logic [N_PROC-1:0] stall_mask;
    logic              ovf_err;
    logic              stall_clr;

    // Sequencer side.
    modport master (
        input  ap_start,
        input  proc_ready,
        input  proc_done,
        input  proc_idle,
        input  stall_clr,
        output ap_ready,
        output ap_done,
        output ap_idle,
        output proc_start,
        output stall,
        output stall_mask,
        output ovf_err
    );

    // Environment side: caller plus the dataflow processes.
    modport slave (
        output ap_start,
        output proc_ready,
        output proc_done,
        output proc_idle,
        output stall_clr,
        input  ap_ready,
        input  ap_done,
        input  ap_idle,
        input  proc_start,
        input  stall,
        input  stall_mask,
        input  ovf_err
    );
endinterface

// File: rtl/dataflow_ctrl_sequencer.sv
// dataflow_ctrl_sequencer: fans ap_start out to the region's processes,
// joins their done pulses into ap_done, and watches for stalls.
module dataflow_ctrl_sequencer #(
    parameter int N_PROC = 3,
    parameter int CNT_W  = 2,
    parameter int WDOG_W = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    dataflow_ctrl_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]    OUT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [WDOG_W-1:0] WD_ONE  = {{(WDOG_W-1){1'b0}}, 1'b1};

    logic [N_PROC-1:0] rdy_flag;
    logic [N_PROC-1:0] accept;
    logic [N_PROC-1:0] cnt_nz;
    logic [CNT_W-1:0]  done_cnt [N_PROC];
    logic [CNT_W:0]    out_cnt;
    logic [WDOG_W-1:0] wd_cnt;
    logic              all_rdy;
    logic              join_ev;
    logic              ovf_hit;
    logic              progress;
    logic              wd_full;
    logic              ap_done_q;
    logic              stall_q;
    logic [N_PROC-1:0] stall_mask_q;
    logic              ovf_q;

    // A process that already took this iteration is not restarted.
    assign bus.proc_start = {N_PROC{bus.ap_start}} & ~rdy_flag;
    assign accept         = bus.proc_start & bus.proc_ready;
    assign all_rdy        = &(rdy_flag | accept);
    assign bus.ap_ready   = bus.ap_start & all_rdy;

    assign bus.ap_done    = ap_done_q;
    assign bus.ap_idle    = (out_cnt == '0) & (&bus.proc_idle);
    assign bus.stall      = stall_q;
    assign bus.stall_mask = stall_mask_q;
    assign bus.ovf_err    = ovf_q;

    assign join_ev  = &cnt_nz;
    assign wd_full  = &wd_cnt;
    assign progress = (|bus.proc_ready) | (|bus.proc_done)
                    | bus.ap_ready | (out_cnt == '0);

    // Join and overflow detection from the registered done counts.
    always_comb begin
        cnt_nz  = '0;
        ovf_hit = 1'b0;
        for (int i = 0; i < N_PROC; i++) begin
            cnt_nz[i] = |done_cnt[i];
            if (bus.proc_done[i] && !join_ev && done_cnt[i] == CNT_MAX)
                ovf_hit = 1'b1;
        end
    end

    // Per-process accepted flags; cleared when the whole region accepts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rdy_flag <= '0;
        else if (bus.ap_ready)
            rdy_flag <= '0;
        else
            rdy_flag <= rdy_flag | accept;
    end

    // Outstanding iterations: started but not yet joined.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            out_cnt <= '0;
        else if (bus.ap_ready && !join_ev)
            out_cnt <= out_cnt + OUT_ONE;
        else if (!bus.ap_ready && join_ev)
            out_cnt <= out_cnt - OUT_ONE;
    end

    // Done-ahead counters, saturating on overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PROC; i++)
                done_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PROC; i++) begin
                if (bus.proc_done[i] && !join_ev) begin
                    if (done_cnt[i] != CNT_MAX)
                        done_cnt[i] <= done_cnt[i] + CNT_ONE;
                end else if (!bus.proc_done[i] && join_ev) begin
                    done_cnt[i] <= done_cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // One-cycle ap_done pulse per join.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ap_done_q <= 1'b0;
        else
            ap_done_q <= join_ev;
    end

    // Watchdog counter: restarts on any sign of progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (bus.stall_clr || progress)
            wd_cnt <= '0;
        else if (!wd_full)
            wd_cnt <= wd_cnt + WD_ONE;
    end

    // Sticky stall flag with a snapshot of the busy processes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q      <= 1'b0;
            stall_mask_q <= '0;
        end else if (bus.stall_clr) begin
            stall_q      <= 1'b0;
            stall_mask_q <= '0;
        end else if (wd_full && !stall_q) begin
            stall_q      <= 1'b1;
            stall_mask_q <= ~bus.proc_idle;
        end
    end

    // Sticky done-counter overflow flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ovf_q <= 1'b0;
        else if (bus.stall_clr)
            ovf_q <= 1'b0;
        else if (ovf_hit)
            ovf_q <= 1'b1;
    end

endmodule

// File: tb/tb_dataflow_ctrl_sequencer.sv
// tb_dataflow_ctrl_sequencer: directed and random stimulus against an
// iteration-level reference model, checked by a decoupled monitor.
module tb_dataflow_ctrl_sequencer;

    localparam int NP    = 3;
    localparam int DMAX  = 3;
    localparam int WDMAX = 1023;

    logic clock = 1'b0;
    logic reset = 1'b1;

    dataflow_ctrl_sequencer_if #(.N_PROC(NP)) bus();

    dataflow_ctrl_sequencer #(
        .N_PROC(NP),
        .CNT_W (2),
        .WDOG_W(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [10:0] exp_q[$];
    int          done_q[$];

    // Reference model: iteration bookkeeping in plain integers.
    bit          acc[NP];
    int          dcnt[NP];
    int          outs;
    int          wd;
    bit          m_stall;
    bit          m_ovf;
    bit          m_done;
    bit [NP-1:0] m_mask;
    bit          m_rdy;

    int starts;
    int dgiven[NP];

    function automatic void m_reset();
        for (int i = 0; i < NP; i++) begin
            acc[i]  = 1'b0;
            dcnt[i] = 0;
        end
        outs    = 0;
        wd      = 0;
        m_stall = 1'b0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_mask  = '0;
        m_rdy   = 1'b0;
    endfunction

    // One clock cycle: drive pulses, predict outputs, advance the model.
    task automatic tick(input logic [NP-1:0] pr, input logic [NP-1:0] pd);
        bit [NP-1:0] ps;
        bit          all_ok;
        bit          idle;
        bit          jn;
        bit          prog;
        int          n;
        bus.proc_ready = pr;
        bus.proc_done  = pd;
        if (!reset) m_reset();
        all_ok = 1'b1;
        for (int i = 0; i < NP; i++) begin
            ps[i] = bus.ap_start && !acc[i];
            if (!(acc[i] || (ps[i] && pr[i]))) all_ok = 1'b0;
        end
        m_rdy = bus.ap_start && all_ok;
        idle  = (outs == 0) && (&bus.proc_idle);
        exp_q.push_back({m_rdy, m_done, idle, ps, m_stall, m_mask, m_ovf});
        if (reset) begin
            jn = 1'b1;
            for (int i = 0; i < NP; i++)
                if (dcnt[i] == 0) jn = 1'b0;
            prog = (pr != 0) || (pd != 0) || m_rdy || (outs == 0);
            for (int i = 0; i < NP; i++) begin
                if (m_rdy) acc[i] = 1'b0;
                else if (ps[i] && pr[i]) acc[i] = 1'b1;
                n = dcnt[i] + int'(pd[i]) - int'(jn);
                if (n > DMAX) begin
                    n     = DMAX;
                    m_ovf = 1'b1;
                end
                dcnt[i] = n;
            end
            outs = outs + int'(m_rdy) - int'(jn);
            if (bus.stall_clr) begin
                m_stall = 1'b0;
                m_mask  = '0;
                m_ovf   = 1'b0;
                wd      = 0;
            end else begin
                if (wd == WDMAX && !m_stall) begin
                    m_stall = 1'b1;
                    m_mask  = ~bus.proc_idle;
                end
                wd = prog ? 0 : ((wd < WDMAX) ? wd + 1 : WDMAX);
            end
            m_done = jn;
            if (jn) done_q.push_back(cyc + 1);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick('0, '0);
    endtask

    task automatic start_all();
        bus.ap_start = 1'b1;
        tick('1, '0);
        bus.ap_start = 1'b0;
    endtask

    // Monitor: compares every cycle's outputs and each ap_done pulse.
    initial begin
        logic [10:0] e;
        logic [10:0] act;
        int          c;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.ap_ready, bus.ap_done, bus.ap_idle,
                       bus.proc_start, bus.stall, bus.stall_mask,
                       bus.ovf_err};
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got=%b exp=%b",
                             cyc, act, e);
                end
            end
            if (bus.ap_done === 1'b1) begin
                tests++;
                if (done_q.size() == 0) begin
                    fails++;
                    $display("FAIL ap_done_unexpected cyc=%0d got=1 exp=0",
                             cyc);
                end else begin
                    c = done_q.pop_front();
                    if (c != cyc) begin
                        fails++;
                        $display("FAIL ap_done_cycle got=%0d exp=%0d",
                                 cyc, c);
                    end
                end
            end
        end
    end

    initial begin
        bus.ap_start   = 1'b0;
        bus.proc_ready = '0;
        bus.proc_done  = '0;
        bus.proc_idle  = '1;
        bus.stall_clr  = 1'b0;
        m_reset();
        #1 reset = 1'b0;
        @(negedge clock);
        tick('0, '0);
        tick('0, '0);
        reset = 1'b1;
        idle_ticks(2);

        // All processes ready in the start cycle.
        bus.proc_idle = '0;
        start_all();
        idle_ticks(2);
        tick('1, '0);
        tick('0, '1);
        idle_ticks(4);

        // Staggered process acceptance.
        bus.ap_start = 1'b1;
        tick(3'b001, '0);
        tick('0, '0);
        tick(3'b010, '0);
        idle_ticks(2);
        tick(3'b100, '0);
        bus.ap_start = 1'b0;
        idle_ticks(4);

        // Done pulses at relative cycles 10, 12 and 15.
        tick('0, 3'b001);
        tick('0, '0);
        tick('0, 3'b010);
        idle_ticks(2);
        tick('0, 3'b100);
        idle_ticks(2);
        bus.proc_idle = '1;
        idle_ticks(3);

        // Done-counter overflow on process 0.
        bus.proc_idle = '0;
        bus.ap_start  = 1'b1;
        for (int k = 0; k < 3; k++) tick('1, '0);
        bus.ap_start = 1'b0;
        for (int k = 0; k < 4; k++) tick('0, 3'b001);
        idle_ticks(2);
        bus.stall_clr = 1'b1;
        tick('0, '0);
        bus.stall_clr = 1'b0;
        for (int k = 0; k < 3; k++) tick('0, 3'b110);
        bus.proc_idle = '1;
        idle_ticks(5);

        // Watchdog stall with processes 0 and 2 idle.
        bus.proc_idle = 3'b101;
        start_all();
        idle_ticks(1030);
        bus.stall_clr = 1'b1;
        tick('0, '0);
        bus.stall_clr = 1'b0;
        idle_ticks(5);
        tick('0, '1);
        bus.proc_idle = '1;
        idle_ticks(4);

        // Asynchronous reset with two iterations outstanding.
        bus.proc_idle = '0;
        bus.ap_start  = 1'b1;
        tick('1, '0);
        tick('1, '0);
        bus.ap_start = 1'b0;
        tick('0, 3'b011);
        reset = 1'b0;
        tick('0, '0);
        tick('0, '0);
        reset = 1'b1;
        idle_ticks(2);
        start_all();
        tick('0, '1);
        bus.proc_idle = '1;
        idle_ticks(4);

        // Random traffic.
        starts = 0;
        for (int i = 0; i < NP; i++) dgiven[i] = 0;
        for (int k = 0; k < 1500; k++) begin
            logic [NP-1:0] pr;
            logic [NP-1:0] pd;
            if (!bus.ap_start && outs < 5 && $urandom_range(0, 2) == 0)
                bus.ap_start = 1'b1;
            pr = NP'($urandom);
            pd = '0;
            for (int i = 0; i < NP; i++) begin
                if (dgiven[i] < starts && $urandom_range(0, 3) == 0) begin
                    pd[i] = 1'b1;
                    dgiven[i]++;
                end
            end
            bus.proc_idle = NP'($urandom);
            bus.stall_clr = ($urandom_range(0, 99) == 0);
            tick(pr, pd);
            if (m_rdy) begin
                starts++;
                if (outs >= 4 || $urandom_range(0, 1) == 0)
                    bus.ap_start = 1'b0;
            end
        end
        bus.ap_start  = 1'b0;
        bus.stall_clr = 1'b0;
        idle_ticks(10);
        #3;
        tests++;
        if (done_q.size() != 0) begin
            fails++;
            $display("FAIL ap_done_missing got=0 exp=%0d pending",
                     done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
